// File: rtl/maxpool_pkg.sv
// Shared definitions for the AXI-Stream maxpool scheduler: FSM states,
// default tuser flag positions and the pool-size clamp applied at config time.
package maxpool_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    localparam int TUSER_W                = 2;
    localparam int IDX_IS_NOT_MAX_DEFAULT = 0;
    localparam int IDX_IS_MAX_DEFAULT     = 1;

    // A zero-length window makes no sense, so it is treated as one beat.
    function automatic logic [3:0] clamp_pool_size(input logic [3:0] size,
                                                   input logic [3:0] max_size);
        logic [3:0] result;
        result = size;
        if (size == 4'd0) begin
            result = 4'd1;
        end else if (size > max_size) begin
            result = max_size;
        end
        return result;
    endfunction

endpackage

// File: rtl/maxpool_window_counter.sv
// Counts accepted beats inside a pooling window and windows inside a frame,
// flagging the closing beat of each window and of the whole frame.
module maxpool_window_counter #(
    parameter int WIN_W = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             clear,
    input  logic             advance,
    input  logic [3:0]       pool_size,
    input  logic [WIN_W-1:0] windows,
    output logic             window_last,
    output logic             frame_last
);

    logic [3:0]       member_q, member_d;
    logic [WIN_W-1:0] window_q, window_d;

    assign window_last = (member_q == pool_size - 4'd1);
    assign frame_last  = window_last && (window_q == windows - WIN_W'(1));

    always_comb begin
        member_d = member_q;
        window_d = window_q;
        if (clear) begin
            member_d = '0;
            window_d = '0;
        end else if (advance) begin
            if (window_last) begin
                member_d = '0;
                window_d = window_q + WIN_W'(1);
            end else begin
                member_d = member_q + 4'd1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            member_q <= '0;
            window_q <= '0;
        end else begin
            member_q <= member_d;
            window_q <= window_d;
        end
    end

endmodule

// File: rtl/axis_maxpool_scheduler.sv
// Tags an AXI-Stream of activation beats with window-close / bypass flags
// for a downstream maxpool engine, one frame per accepted configuration.
module axis_maxpool_scheduler
    import maxpool_pkg::*;
#(
    parameter int UNITS            = 8,
    parameter int GROUPS           = 2,
    parameter int MEMEBERS         = 8,
    parameter int WORD_WIDTH       = 8,
    parameter int INDEX_IS_NOT_MAX = IDX_IS_NOT_MAX_DEFAULT,
    parameter int INDEX_IS_MAX     = IDX_IS_MAX_DEFAULT,
    parameter int WIN_W            = 16
) (
    input  logic                                    aclk,
    input  logic                                    areset,
    input  logic                                    cfg_valid,
    output logic                                    cfg_ready,
    input  logic [3:0]                              cfg_pool_size,
    input  logic [WIN_W-1:0]                        cfg_windows,
    input  logic                                    cfg_bypass,
    input  logic                                    s_axis_tvalid,
    output logic                                    s_axis_tready,
    input  logic [GROUPS*UNITS*2*WORD_WIDTH-1:0]    s_axis_tdata,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready,
    output logic [GROUPS*UNITS*2*WORD_WIDTH-1:0]    m_axis_tdata,
    output logic [TUSER_W-1:0]                      m_axis_tuser,
    output logic                                    busy,
    output logic                                    done
);

    localparam int         DATA_W   = GROUPS * UNITS * 2 * WORD_WIDTH;
    localparam logic [3:0] MAX_POOL = 4'(MEMEBERS);

    sched_state_e        state_q, state_d;
    logic [3:0]          pool_q, pool_d;
    logic [WIN_W-1:0]    windows_q, windows_d;
    logic                bypass_q, bypass_d;
    logic                drain_q, drain_d;
    logic                m_valid_q;
    logic [TUSER_W-1:0]  tuser_q, tuser_d;
    logic [DATA_W-1:0]   tdata_q;

    logic cfg_accept;
    logic s_hs;
    logic m_hs;
    logic window_last;
    logic frame_last;

    assign cfg_accept    = (state_q == IDLE) && cfg_valid;
    assign s_axis_tready = (state_q == RUN) && !drain_q && (!m_valid_q || m_axis_tready);
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign m_hs          = m_valid_q && m_axis_tready;

    assign cfg_ready     = (state_q == IDLE);
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tdata  = tdata_q;

    maxpool_window_counter #(
        .WIN_W (WIN_W)
    ) u_counter (
        .aclk        (aclk),
        .areset      (areset),
        .clear       (cfg_accept),
        .advance     (s_hs),
        .pool_size   (pool_q),
        .windows     (windows_q),
        .window_last (window_last),
        .frame_last  (frame_last)
    );

    // drain_q marks that the final beat is already in the output register,
    // so upstream is closed until that beat leaves downstream.
    always_comb begin
        state_d   = state_q;
        pool_d    = pool_q;
        windows_d = windows_q;
        bypass_d  = bypass_q;
        drain_d   = drain_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    pool_d    = cfg_bypass ? 4'd1 : clamp_pool_size(cfg_pool_size, MAX_POOL);
                    windows_d = cfg_windows;
                    bypass_d  = cfg_bypass;
                    drain_d   = 1'b0;
                    state_d   = (cfg_windows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (s_hs && frame_last) begin
                    drain_d = 1'b1;
                end
                if (drain_q && m_hs) begin
                    drain_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            pool_q    <= 4'd1;
            windows_q <= '0;
            bypass_q  <= 1'b0;
            drain_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pool_q    <= pool_d;
            windows_q <= windows_d;
            bypass_q  <= bypass_d;
            drain_q   <= drain_d;
        end
    end

    always_comb begin
        tuser_d                       = '0;
        tuser_d[1'(INDEX_IS_MAX)]     = window_last;
        tuser_d[1'(INDEX_IS_NOT_MAX)] = bypass_q;
    end

    // Single skid-free output stage: a new beat may load in the same cycle
    // the previous one drains, which keeps one beat per cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_valid_q <= 1'b0;
            tuser_q   <= '0;
        end else if (s_hs) begin
            m_valid_q <= 1'b1;
            tuser_q   <= tuser_d;
        end else if (m_axis_tready) begin
            m_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (s_hs) begin
            tdata_q <= s_axis_tdata;
        end
    end

endmodule

// File: tb/tb_axis_maxpool_scheduler.sv
// Directed self-checking bench for axis_maxpool_scheduler: frame timing,
// window flags, stall stability, bypass, config clamping and async reset.
module tb_axis_maxpool_scheduler;

    localparam int DATA_W = 256;

    logic              aclk;
    logic              areset;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [3:0]        cfg_pool_size;
    logic [15:0]       cfg_windows;
    logic              cfg_bypass;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [1:0]        m_axis_tuser;
    logic              busy;
    logic              done;

    int vectors;
    int miscompares;

    axis_maxpool_scheduler dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_pool_size (cfg_pool_size),
        .cfg_windows   (cfg_windows),
        .cfg_bypass    (cfg_bypass),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .busy          (busy),
        .done          (done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [DATA_W-1:0] beatData(input int n);
        logic [31:0] w;
        w = 32'hA500_0000 + 32'(n);
        return {8{w}};
    endfunction

    // Reference tag for downstream beat k: bit1 closes a window, bit0 is bypass.
    function automatic logic [1:0] expUser(input int k, input int p, input bit byp);
        logic [1:0] u;
        u    = 2'b00;
        u[1] = ((k % p) == (p - 1));
        u[0] = byp;
        return u;
    endfunction

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] pool, input logic [15:0] wins, input bit byp);
        cfg_pool_size = pool;
        cfg_windows   = wins;
        cfg_bypass    = byp;
        cfg_valid     = 1'b1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".tvalid"}, 256'(m_axis_tvalid), 256'(0));
        checkOutput({tag, ".tuser"},  256'(m_axis_tuser),  256'(0));
        checkOutput({tag, ".busy"},   256'(busy),          256'(0));
        checkOutput({tag, ".cfgRdy"}, 256'(cfg_ready),     256'(1));
        checkOutput({tag, ".sRdy"},   256'(s_axis_tready), 256'(0));
    endtask

    // readyMode 0 keeps m_axis_tready high; 1 toggles it 1,0,1,0 per cycle.
    task automatic runFrame(input string tag, input logic [3:0] pool, input logic [15:0] wins,
                            input bit byp, input int readyMode, input bit holdCfg,
                            input int expDoneCyc, input int resetAt);
        int p, expBeats, sent, got, doneCyc, doneCnt, budget;
        bit stalled;
        logic [DATA_W-1:0] heldData;
        logic [1:0] heldUser;

        p        = byp ? 1 : ((pool == 4'd0) ? 1 : ((pool > 4'd8) ? 8 : int'(pool)));
        expBeats = p * int'(wins);
        sent     = 0;
        got      = 0;
        doneCyc  = -1;
        doneCnt  = 0;
        stalled  = 1'b0;
        heldData = '0;
        heldUser = '0;

        @(posedge aclk); #1;
        applyStimulus(pool, wins, byp);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beatData(0);
        m_axis_tready = 1'b1;
        budget = 0;
        @(negedge aclk);
        while (!cfg_ready && budget < 50) begin
            @(negedge aclk);
            budget++;
        end
        checkOutput({tag, ".cfgRdyAtStart"}, 256'(cfg_ready), 256'(1));
        @(posedge aclk); #1;
        if (!holdCfg) cfg_valid = 1'b0;

        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (readyMode == 1) m_axis_tready = (cyc % 2) == 1;
            s_axis_tdata = beatData(sent);
            @(negedge aclk);
            if (cyc == 1 && wins != 16'd0) begin
                checkOutput({tag, ".busyRun"},   256'(busy),      256'(1));
                checkOutput({tag, ".cfgRdyRun"}, 256'(cfg_ready), 256'(0));
            end
            if (stalled) begin
                checkOutput({tag, ".stallValid"}, 256'(m_axis_tvalid), 256'(1));
                checkOutput({tag, ".stallData"},  m_axis_tdata,        heldData);
                checkOutput({tag, ".stallUser"},  256'(m_axis_tuser),  256'(heldUser));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checkOutput($sformatf("%s.user%0d", tag, got), 256'(m_axis_tuser),
                            256'(expUser(got, p, byp)));
                checkOutput($sformatf("%s.data%0d", tag, got), m_axis_tdata, beatData(got));
                got++;
            end
            stalled  = m_axis_tvalid && !m_axis_tready;
            heldData = m_axis_tdata;
            heldUser = m_axis_tuser;
            if (s_axis_tvalid && s_axis_tready) sent++;
            if (done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            if (resetAt >= 0 && got == resetAt) begin
                @(posedge aclk); #2;
                areset = 1'b1;
                #1;
                checkIdle({tag, ".midReset"});
                s_axis_tvalid = 1'b0;
                @(posedge aclk); #1;
                areset = 1'b0;
                return;
            end
            if (doneCyc >= 0 && cyc == doneCyc + 1) begin
                checkOutput({tag, ".idleAfterDone"}, 256'(cfg_ready), 256'(1));
                checkOutput({tag, ".busyAfterDone"}, 256'(busy),      256'(0));
                break;
            end
            @(posedge aclk); #1;
        end

        checkOutput({tag, ".beats"},     256'(got),     256'(expBeats));
        checkOutput({tag, ".sent"},      256'(sent),    256'(expBeats));
        checkOutput({tag, ".donePulse"}, 256'(doneCnt), 256'(1));
        if (expDoneCyc > 0) checkOutput({tag, ".doneCycle"}, 256'(doneCyc), 256'(expDoneCyc));
        s_axis_tvalid = 1'b0;

        if (holdCfg) begin
            @(posedge aclk); #1;
            cfg_valid = 1'b0;
            @(negedge aclk);
            checkOutput({tag, ".nextCfgTaken"}, 256'(busy), 256'(1));
            @(posedge aclk); #1;
            areset = 1'b1;
            @(posedge aclk); #1;
            areset = 1'b0;
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        areset        = 1'b1;
        cfg_valid     = 1'b0;
        cfg_pool_size = 4'd0;
        cfg_windows   = 16'd0;
        cfg_bypass    = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkIdle("reset");
        checkOutput("reset.done", 256'(done), 256'(0));
        @(posedge aclk); #1;
        areset = 1'b0;

        runFrame("pool4x2",   4'd4, 16'd2, 1'b0, 0, 1'b0, 10, -1);
        runFrame("pool3stall", 4'd3, 16'd2, 1'b0, 1, 1'b0, -1, -1);
        runFrame("bypass5",   4'd4, 16'd5, 1'b1, 0, 1'b0, 7, -1);
        runFrame("pool0x3",   4'd0, 16'd3, 1'b0, 0, 1'b0, 5, -1);
        runFrame("pool12x1",  4'd12, 16'd1, 1'b0, 0, 1'b0, 10, -1);
        runFrame("win0",      4'd4, 16'd0, 1'b0, 0, 1'b0, 1, -1);
        runFrame("rst4x4",    4'd4, 16'd4, 1'b0, 0, 1'b0, -1, 5);
        runFrame("afterRst",  4'd4, 16'd2, 1'b0, 0, 1'b0, 10, -1);
        runFrame("holdCfg",   4'd2, 16'd2, 1'b0, 0, 1'b1, 6, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_maxpool_scheduler.md
AXIS_MAXPOOL_SCHEDULER -- requirements
Module: axis_maxpool_scheduler

Interface
REQ-001 Parameter UNITS, default 8, units per group.
REQ-002 Parameter GROUPS, default 2, groups per beat.
REQ-003 Parameter MEMEBERS, default 8, maximum pooling-window size in beats.
REQ-004 Parameter WORD_WIDTH, default 8, bits per word.
REQ-005 Parameter INDEX_IS_NOT_MAX, default 0, tuser bit index for the bypass (no-pool) flag.
REQ-006 Parameter INDEX_IS_MAX, default 1, tuser bit index for the window-close flag.
REQ-007 Parameter WIN_W, default 16, width of the window counter.
REQ-008 aclk  in  1  single clock; all logic rising-edge.
REQ-009 areset  in  1  asynchronous, active-high reset.
REQ-010 cfg_valid  in  1  config handshake valid.
REQ-011 cfg_ready  out  1  config handshake ready.
REQ-012 cfg_pool_size  in  4  beats per window (1..MEMEBERS).
REQ-013 cfg_windows  in  WIN_W  windows per frame.
REQ-014 cfg_bypass  in  1  1 = no pooling, tag every beat INDEX_IS_NOT_MAX.
REQ-015 s_axis_tvalid / s_axis_tready  in / out  1 / 1  upstream handshake.
REQ-016 s_axis_tdata  in  GROUPS*UNITS*2*WORD_WIDTH  upstream data.
REQ-017 m_axis_tvalid / m_axis_tready  out / in  1 / 1  handshake toward the maxpool engine.
REQ-018 m_axis_tdata  out  GROUPS*UNITS*2*WORD_WIDTH  data toward the engine.
REQ-019 m_axis_tuser  out  2  bit 0 = first tuser bit, bit 1 = second; indexed by INDEX_IS_NOT_MAX / INDEX_IS_MAX.
REQ-020 busy  out  1  high in RUN.
REQ-021 done  out  1  one-cycle pulse when the frame completes.

Function
REQ-022 FSM states: IDLE, RUN, DONE.
REQ-023 IDLE: cfg_ready=1 and s_axis_tready=0. A cfg handshake latches pool_size, windows and bypass, clears both counters and moves to RUN.
REQ-024 cfg_pool_size=0 is latched as 1. cfg_pool_size>MEMEBERS is latched as MEMEBERS. cfg_windows=0 goes directly to DONE.
REQ-025 RUN: cfg_ready=0. A cfg_valid asserted in RUN is ignored and not consumed.
REQ-026 Output stage is a single register. Latency is 1 cycle from s-handshake to m_axis_tvalid.
REQ-027 s_axis_tready = (state==RUN) and (!m_axis_tvalid or m_axis_tready). This gives full throughput of one beat per cycle.
REQ-028 m_axis_tvalid, tdata and tuser are held stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-029 member_cnt counts accepted beats 0..pool_size-1 and wraps to 0 on the last beat of a window. window_cnt then increments.
REQ-030 tuser[INDEX_IS_MAX]=1 on the beat where member_cnt==pool_size-1, otherwise 0.
REQ-031 tuser[INDEX_IS_NOT_MAX] equals the latched bypass value on every beat. In bypass, INDEX_IS_MAX is also set on every beat, because the window size is forced to 1.
REQ-032 When the last beat of the last window is accepted upstream, s_axis_tready drops next cycle and the FSM waits for that beat's m-handshake.
REQ-033 After that m-handshake the FSM enters DONE. done=1 for exactly one cycle, then IDLE.
REQ-034 busy=1 only in RUN.
REQ-035 Simultaneous upstream accept and downstream drain in the same cycle are legal and lose no beat.

Reset
REQ-036 areset asserted at any time, including mid-frame, forces state=IDLE asynchronously.
REQ-037 Reset values: m_axis_tvalid=0, m_axis_tuser=0, counters=0, done=0, busy=0, cfg_ready=1, s_axis_tready=0.
REQ-038 m_axis_tdata has no reset requirement.
REQ-039 A beat in flight at reset is discarded.

Structure
REQ-040 State encoding and tuser bit-index constants shall live in the shared maxpool package.
REQ-041 The counter and flag logic shall be one sub-module, maxpool_window_counter. It takes pool_size, windows and an advance input, and produces window_last and frame_last.
REQ-042 The output register stays in the top module.

Verification
REQ-043 Pool 4, windows 2, bypass 0, continuous valid and ready → 8 beats with INDEX_IS_MAX on beats 4 and 8, done on cycle 10 after the cfg handshake.
REQ-044 Pool 3, windows 2, m_axis_tready toggling 1,0,1,0 → no beat lost or duplicated, and data/tuser stable during stalls.
REQ-045 Bypass 1, windows 5 → 5 beats, all with tuser=2'b11, then one done pulse.
REQ-046 cfg_pool_size=0, windows 3 → 3 beats, each with INDEX_IS_MAX=1. cfg_windows=0 → done one cycle after cfg with no beats.
REQ-047 areset asserted after beat 5 of a pool 4 × 4 frame → m_axis_tvalid=0 immediately, IDLE, cfg_ready=1. A new frame after release behaves like REQ-043.
REQ-048 cfg_valid held high throughout RUN → only one cfg accepted per frame, and the next cfg is accepted only in the cycle after done.
